sha512_masked_schedule_ctrl: RTL

Sequences the SHA-512 message schedule in the masked (d-share) domain. It accepts 16 masked message words and keeps them in a 16-entry share buffer. It then generates W16..W79 by driving the XOR-only sigma gadgets and an external masked 4-operand adder through a request/acknowledge handshake. All 80 schedule words are streamed to the masked compression core over a valid/ready output.

---
 rtl/sha512_masked_schedule_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sha512_masked_schedule_ctrl.sv
// Masked SHA-512 message-schedule sequencer and its share-wise sigma gadgets.
// Words use a d-share Boolean layout: bit b of share s sits at index b*d+s.

// Small sigma0 (rotr1 ^ rotr8 ^ shr7), applied independently to each share.
// It is linear over XOR, so no randomness is needed and shares never mix.
module sha_sigma_L0_gadget #(
    parameter int d = 2
) (
    input  logic [d*64-1:0] x,
    output logic [d*64-1:0] y
);
    for (genvar s = 0; s < d; s++) begin : g_share
        logic [63:0] w;
        logic [63:0] r;
        for (genvar b = 0; b < 64; b++) begin : g_bit
            assign w[b]     = x[b*d+s];
            assign y[b*d+s] = r[b];
        end
        assign r = {w[0], w[63:1]} ^ {w[7:0], w[63:8]} ^ (w >> 7);
    end
endmodule

// Small sigma1 (rotr19 ^ rotr61 ^ shr6), applied independently to each share.
module sha_sigma_L1_gadget #(
    parameter int d = 2
) (
    input  logic [d*64-1:0] x,
    output logic [d*64-1:0] y
);
    for (genvar s = 0; s < d; s++) begin : g_share
        logic [63:0] w;
        logic [63:0] r;
        for (genvar b = 0; b < 64; b++) begin : g_bit
            assign w[b]     = x[b*d+s];
            assign y[b*d+s] = r[b];
        end
        assign r = {w[18:0], w[63:19]} ^ {w[60:0], w[63:61]} ^ (w >> 6);
    end
endmodule

// Schedule controller: loads W0..W15, then produces W16..W79 through an
// external masked adder, streaming every word out over valid/ready.
module sha512_masked_schedule_ctrl #(
    parameter int d      = 2,
    parameter int ROUNDS = 80
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic [d*64-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [d*64-1:0] w_data,
    output logic [6:0]      w_index,
    output logic            w_valid,
    input  logic            w_ready,
    output logic [d*64-1:0] add_op0,
    output logic [d*64-1:0] add_op1,
    output logic [d*64-1:0] add_op2,
    output logic [d*64-1:0] add_op3,
    output logic            add_req,
    input  logic [d*64-1:0] add_res,
    input  logic            add_ack
);
    localparam int         WB        = d * 64;
    localparam logic [6:0] LAST_T    = 7'(ROUNDS - 1);
    localparam logic [6:0] LOAD_LAST = 7'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [6:0]    t;
    logic [WB-1:0] share_buf [16];   // [15] = W[t-1] ... [0] = W[t-16]
    logic          free;
    logic          load_en;
    logic          t_clear;
    logic          done_set;
    logic [WB-1:0] load_word;

    // Adder operands come straight from the buffer; the adder samples them at add_req.
    sha_sigma_L1_gadget #(.d(d)) u_sigma1 (.x(share_buf[14]), .y(add_op0));
    sha_sigma_L0_gadget #(.d(d)) u_sigma0 (.x(share_buf[1]),  .y(add_op2));
    assign add_op1 = share_buf[9];
    assign add_op3 = share_buf[0];

    assign busy = (state != S_IDLE);
    assign free = !w_valid || w_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_next = state;
        in_ready   = 1'b0;
        add_req    = 1'b0;
        load_en    = 1'b0;
        load_word  = in_data;
        t_clear    = 1'b0;
        done_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD;
                    t_clear    = 1'b1;
                end
            end
            S_LOAD: begin
                in_ready = free;
                if (in_valid && free) begin
                    load_en = 1'b1;
                    if (t == LOAD_LAST) state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Waiting for free here guarantees the output register can take the sum.
                if (free) begin
                    add_req    = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (add_ack) begin
                    load_en    = 1'b1;
                    load_word  = add_res;
                    state_next = (t == LAST_T) ? S_DRAIN : S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (w_valid && w_ready) begin
                    state_next = S_IDLE;
                    done_set   = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output word register, schedule counter and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t       <= '0;
            w_data  <= '0;
            w_index <= '0;
            w_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= done_set;
            if (t_clear)      t <= '0;
            else if (load_en) t <= t + 7'd1;
            if (load_en) begin
                w_data  <= load_word;
                w_index <= t;
                w_valid <= 1'b1;
            end else if (w_ready) begin
                w_valid <= 1'b0;
            end
        end
    end

    // Share buffer: the newest word enters at [15] and everything shifts toward [0].
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the buffer is cleared on reset, so it is built from resettable flops rather than a RAM.
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) share_buf[i] <= '0;
        end else if (load_en) begin
            for (int i = 0; i < 15; i++) share_buf[i] <= share_buf[i+1];
            share_buf[15] <= load_word;
        end
    end
endmodule
